// File: rtl/vit_llr_depunct_if.sv
// rtl/vit_llr_depunct_if.sv - soft-sample input / depunctured-symbol output bundle for vit_llr_depunct
interface vit_llr_depunct_if #(
    parameter int pCODE_GEN_NUM = 2,
    parameter int pDAT_W        = 16,
    parameter int pLLR_W        = 4
);
    logic                                 isop;
    logic                                 ieop;
    logic                                 ival;
    logic signed [pDAT_W-1:0]             idat;
    logic                                 osop;
    logic                                 oeop;
    logic                                 oval;
    logic [pCODE_GEN_NUM-1:0]             odat;
    logic [pCODE_GEN_NUM-1:0][pLLR_W-1:0] oLLR;
    logic [pCODE_GEN_NUM-1:0]             oera;

    modport master (
        output isop, ieop, ival, idat,
        input  osop, oeop, oval, odat, oLLR, oera
    );

    modport slave (
        input  isop, ieop, ival, idat,
        output osop, oeop, oval, odat, oLLR, oera
    );
endinterface

// File: rtl/vit_llr_depunct.sv
// rtl/vit_llr_depunct.sv - soft-sample quantizer and depuncturer feeding the 1/N Viterbi decoder
module vit_llr_depunct #(
    parameter int pCODE_GEN_NUM = 2,
    parameter int pDAT_W        = 16,
    parameter int pREF_LOG2     = 10,
    parameter int pLLR_W        = 4,
    parameter int pPUNCT_PERIOD = 1,
    parameter logic [pCODE_GEN_NUM*pPUNCT_PERIOD-1:0] pPUNCT_MASK = '1
) (
    input  logic          iclk,
    input  logic          ireset,
    input  logic          iclkena,
    vit_llr_depunct_if.slave ch
);

    localparam int N      = pCODE_GEN_NUM;
    localparam int MASK_W = pCODE_GEN_NUM * pPUNCT_PERIOD;
    localparam int COL_W  = (pPUNCT_PERIOD > 1) ? $clog2(pPUNCT_PERIOD) : 1;
    localparam int SLOT_W = (N > 1) ? $clog2(N) : 1;
    localparam int SH     = pREF_LOG2 + 2 - pLLR_W;

    localparam logic signed [pDAT_W-1:0] SAT_MAX = signed'(pDAT_W'((1 << (pREF_LOG2 + 1)) - 1));
    localparam logic signed [pDAT_W-1:0] SAT_MIN = -SAT_MAX;

    typedef logic [COL_W-1:0]  col_t;
    typedef logic [SLOT_W-1:0] slot_t;

    localparam col_t LAST_COL = col_t'(pPUNCT_PERIOD - 1);

    function automatic logic kept(input col_t col, input int g);
        logic [MASK_W-1:0] m;
        m = pPUNCT_MASK >> (int'(col) * N + g);
        return m[0];
    endfunction

    // Slots are filled from code bit N-1 downwards, so the first kept slot is the highest kept index.
    function automatic slot_t first_kept(input col_t col);
        slot_t r;
        r = '0;
        for (int g = 0; g < N; g++) begin
            if (kept(col, g)) r = slot_t'(g);
        end
        return r;
    endfunction

    function automatic logic has_next(input col_t col, input slot_t slot);
        logic r;
        r = 1'b0;
        for (int g = 0; g < N; g++) begin
            if (g < int'(slot) && kept(col, g)) r = 1'b1;
        end
        return r;
    endfunction

    function automatic slot_t next_kept(input col_t col, input slot_t slot);
        slot_t r;
        r = '0;
        for (int g = 0; g < N; g++) begin
            if (g < int'(slot) && kept(col, g)) r = slot_t'(g);
        end
        return r;
    endfunction

    logic signed [pDAT_W-1:0] sat;
    logic [pLLR_W-1:0]        llr_v;
    logic                     hard_v;

    col_t                     col_q, col_d;
    slot_t                    slot_q, slot_d;
    logic                     sop_pend_q, sop_pend_d;
    logic [N-1:0]             fill_q, fill_d;
    logic [N-1:0]             sym_dat_q, sym_dat_d;
    logic [N-1:0][pLLR_W-1:0] sym_llr_q, sym_llr_d;

    logic                     oval_q, oval_d;
    logic                     osop_q, osop_d;
    logic                     oeop_q, oeop_d;
    logic [N-1:0]             odat_q, odat_d;
    logic [N-1:0]             oera_q, oera_d;
    logic [N-1:0][pLLR_W-1:0] ollr_q, ollr_d;

    col_t                     cur_col, nxt_col;
    slot_t                    cur_slot;
    logic                     sop_w;
    logic [N-1:0]             fill_w;
    logic [N-1:0]             dat_w;
    logic [N-1:0][pLLR_W-1:0] llr_w;

    // Adding the sign bit after the arithmetic shift folds -2^(pLLR_W-1) away, keeping the range symmetric.
    always_comb begin
        if (ch.idat > SAT_MAX) begin
            sat = SAT_MAX;
        end else if (ch.idat < SAT_MIN) begin
            sat = SAT_MIN;
        end else begin
            sat = ch.idat;
        end
        llr_v  = pLLR_W'(sat >>> SH) + {{(pLLR_W-1){1'b0}}, sat[pDAT_W-1]};
        hard_v = ~sat[pDAT_W-1];
    end

    always_comb begin
        col_d      = col_q;
        slot_d     = slot_q;
        sop_pend_d = sop_pend_q;
        fill_d     = fill_q;
        sym_dat_d  = sym_dat_q;
        sym_llr_d  = sym_llr_q;
        oval_d     = 1'b0;
        osop_d     = 1'b0;
        oeop_d     = 1'b0;
        odat_d     = '0;
        oera_d     = '0;
        ollr_d     = '0;
        cur_col    = col_q;
        cur_slot   = slot_q;
        nxt_col    = '0;
        sop_w      = sop_pend_q;
        fill_w     = fill_q;
        dat_w      = sym_dat_q;
        llr_w      = sym_llr_q;

        if (ch.ival) begin
            // A new packet always realigns to column 0 and drops any partial symbol.
            if (ch.isop) begin
                cur_col  = '0;
                cur_slot = first_kept('0);
                sop_w    = 1'b1;
                fill_w   = '0;
                dat_w    = '0;
                llr_w    = '0;
            end
            fill_w[cur_slot] = 1'b1;
            dat_w[cur_slot]  = hard_v;
            llr_w[cur_slot]  = llr_v;

            if (ch.ieop || !has_next(cur_col, cur_slot)) begin
                oval_d     = 1'b1;
                osop_d     = sop_w;
                oeop_d     = ch.ieop;
                odat_d     = dat_w;
                ollr_d     = llr_w;
                oera_d     = ~fill_w;
                sop_pend_d = 1'b0;
                fill_d     = '0;
                sym_dat_d  = '0;
                sym_llr_d  = '0;
                nxt_col    = (ch.ieop || cur_col == LAST_COL) ? col_t'(0) : col_t'(cur_col + 1'b1);
                col_d      = nxt_col;
                slot_d     = first_kept(nxt_col);
            end else begin
                col_d      = cur_col;
                slot_d     = next_kept(cur_col, cur_slot);
                sop_pend_d = sop_w;
                fill_d     = fill_w;
                sym_dat_d  = dat_w;
                sym_llr_d  = llr_w;
            end
        end
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            col_q      <= '0;
            slot_q     <= first_kept('0);
            sop_pend_q <= 1'b0;
            fill_q     <= '0;
            sym_dat_q  <= '0;
            sym_llr_q  <= '0;
            oval_q     <= 1'b0;
            osop_q     <= 1'b0;
            oeop_q     <= 1'b0;
            odat_q     <= '0;
            oera_q     <= '0;
            ollr_q     <= '0;
        end else if (iclkena) begin
            col_q      <= col_d;
            slot_q     <= slot_d;
            sop_pend_q <= sop_pend_d;
            fill_q     <= fill_d;
            sym_dat_q  <= sym_dat_d;
            sym_llr_q  <= sym_llr_d;
            oval_q     <= oval_d;
            osop_q     <= osop_d;
            oeop_q     <= oeop_d;
            odat_q     <= odat_d;
            oera_q     <= oera_d;
            ollr_q     <= ollr_d;
        end
    end

    assign ch.oval = oval_q;
    assign ch.osop = osop_q;
    assign ch.oeop = oeop_q;
    assign ch.odat = odat_q;
    assign ch.oera = oera_q;
    assign ch.oLLR = ollr_q;

endmodule

// File: tb/tb_vit_llr_depunct.sv
// tb/tb_vit_llr_depunct.sv - randomized self-checking bench for vit_llr_depunct (rate 1/2 and rate 2/3 instances)
module tb_vit_llr_depunct;

    typedef logic [13:0] sym_t;   // {sop, eop, dat[1:0], era[1:0], llr1[3:0], llr0[3:0]}

    logic iclk = 1'b0;
    logic ireset;
    logic iclkena;
    logic en_q = 1'b0;

    int   n_cmp = 0;
    int   n_bad = 0;
    sym_t obs_a[$], obs_b[$], exp_a[$], exp_b[$];

    always #5 iclk = ~iclk;

    vit_llr_depunct_if #(.pCODE_GEN_NUM(2), .pDAT_W(16), .pLLR_W(4)) ifa ();
    vit_llr_depunct_if #(.pCODE_GEN_NUM(2), .pDAT_W(16), .pLLR_W(4)) ifb ();

    vit_llr_depunct u_a (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .ch      (ifa)
    );

    vit_llr_depunct #(.pPUNCT_PERIOD(2), .pPUNCT_MASK(4'b1011)) u_b (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .ch      (ifb)
    );

    always @(posedge iclk) en_q <= iclkena;

    // Record a symbol only when it was produced by an enabled edge, so a frozen oval is not counted twice.
    always @(negedge iclk) begin
        if (ireset === 1'b1 && en_q === 1'b1) begin
            if (ifa.oval === 1'b1) obs_a.push_back({ifa.osop, ifa.oeop, ifa.odat, ifa.oera, ifa.oLLR});
            if (ifb.oval === 1'b1) obs_b.push_back({ifb.osop, ifb.oeop, ifb.odat, ifb.oera, ifb.oLLR});
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int osz(input int w);
        return (w != 0) ? obs_b.size() : obs_a.size();
    endfunction
    function automatic int esz(input int w);
        return (w != 0) ? exp_b.size() : exp_a.size();
    endfunction
    function automatic sym_t oat(input int w, input int i);
        return (w != 0) ? obs_b[i] : obs_a[i];
    endfunction
    function automatic sym_t eat(input int w, input int i);
        return (w != 0) ? exp_b[i] : exp_a[i];
    endfunction

    function automatic int quant(input int x);
        int s;
        s = (x > 2047) ? 2047 : ((x < -2047) ? -2047 : x);
        if (s >= 0) return s / 256;
        return -((-s + 255) / 256) + 1;
    endfunction

    // Reference: walk the puncture columns, pulling samples into kept slots from code bit 1 down to 0.
    function automatic void model(input int w, input int smp[$], input bit has_eop);
        int         per, i, col, l1, l0;
        logic [3:0] mask;
        logic [1:0] dat, era;
        bit         first, short_col;
        sym_t       s;
        per   = (w != 0) ? 2 : 1;
        mask  = (w != 0) ? 4'b1011 : 4'b0011;
        i     = 0;
        col   = 0;
        first = 1'b1;
        while (i < smp.size()) begin
            dat = '0; era = '0; l1 = 0; l0 = 0; short_col = 1'b0;
            for (int g = 1; g >= 0; g--) begin
                if (((mask >> (col * 2 + g)) & 4'd1) != 4'd0) begin
                    if (i < smp.size()) begin
                        if (g == 1) l1 = quant(smp[i]); else l0 = quant(smp[i]);
                        if (smp[i] >= 0) dat = dat | 2'(1 << g);
                        i++;
                    end else begin
                        short_col = 1'b1;
                        era = era | 2'(1 << g);
                    end
                end else begin
                    era = era | 2'(1 << g);
                end
            end
            if (!short_col || has_eop) begin
                s = {first, (has_eop && i == smp.size()) ? 1'b1 : 1'b0, dat, era, 4'(l1), 4'(l0)};
                if (w != 0) exp_b.push_back(s); else exp_a.push_back(s);
                first = 1'b0;
            end
            col = (col + 1) % per;
        end
    endfunction

    task automatic clear_q();
        obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
    endtask

    task automatic drive(input bit sop, input bit eop, input bit val, input int d);
        ifa.isop = sop; ifb.isop = sop;
        ifa.ieop = eop; ifb.ieop = eop;
        ifa.ival = val; ifb.ival = val;
        ifa.idat = 16'(d); ifb.idat = 16'(d);
    endtask

    task automatic send(input int smp[$], input bit sop, input bit eop, input bit gaps, input bit entog);
        for (int i = 0; i < smp.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                drive(1'b0, 1'b0, 1'b0, 0);
                iclkena = 1'b1;
                @(negedge iclk);
            end
            drive(sop && i == 0, eop && i == smp.size() - 1, 1'b1, smp[i]);
            do begin
                iclkena = entog ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge iclk);
            end while (!iclkena);
        end
        drive(1'b0, 1'b0, 1'b0, 0);
        iclkena = 1'b1;
    endtask

    task automatic rand_pkt(input bit eop, input int maxlen, input bit gaps, input bit entog);
        int smp[$];
        int len;
        len = int'($urandom_range(1, maxlen));
        for (int i = 0; i < len; i++) smp.push_back(int'($urandom_range(0, 10000)) - 5000);
        model(0, smp, eop);
        model(1, smp, eop);
        send(smp, 1'b1, eop, gaps, entog);
    endtask

    task automatic drain();
        iclkena = 1'b1;
        repeat (4) @(negedge iclk);
    endtask

    task automatic test_reset();
        ireset  = 1'b1;
        iclkena = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0);
        #2 ireset = 1'b0;
        #1;
        n_cmp++;
        if ({ifa.oval, ifa.osop, ifa.oeop, ifa.odat, ifa.oera, ifa.oLLR} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset dut0 outputs: got %h expected 0", {ifa.oval, ifa.osop, ifa.oeop, ifa.odat, ifa.oera, ifa.oLLR});
        end
        n_cmp++;
        if ({ifb.oval, ifb.osop, ifb.oeop, ifb.odat, ifb.oera, ifb.oLLR} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset dut1 outputs: got %h expected 0", {ifb.oval, ifb.osop, ifb.oeop, ifb.odat, ifb.oera, ifb.oLLR});
        end
        repeat (2) @(negedge iclk);
        ireset  = 1'b1;
        iclkena = 1'b1;
        @(negedge iclk);
    endtask

    task automatic test_rate_half();
        string name = "rate_half";
        int smp[$];
        clear_q();
        smp = '{1024, -1024};
        model(0, smp, 1'b1);
        model(1, smp, 1'b1);
        send(smp, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({ifa.oval, ifa.osop, ifa.oeop, ifa.odat, ifa.oera, ifa.oLLR} !== {3'b111, 2'b10, 2'b00, 8'h4D}) begin
            n_bad++;
            $display("FAIL %s latency/value: got %h expected %h", name,
                     {ifa.oval, ifa.osop, ifa.oeop, ifa.odat, ifa.oera, ifa.oLLR}, {3'b111, 2'b10, 2'b00, 8'h4D});
        end
        @(negedge iclk);
        n_cmp++;
        if (ifa.oval !== 1'b0) begin
            n_bad++;
            $display("FAIL %s oval pulse: got %b expected 0", name, ifa.oval);
        end
        for (int p = 0; p < 4; p++) rand_pkt(1'b1, 8, 1'b1, 1'b0);
        drain();
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (osz(w) !== esz(w)) begin
                n_bad++;
                $display("FAIL %s dut%0d symbol count: got %0d expected %0d", name, w, osz(w), esz(w));
            end
            for (int i = 0; i < esz(w) && i < osz(w); i++) begin
                n_cmp++;
                if (oat(w, i) !== eat(w, i)) begin
                    n_bad++;
                    $display("FAIL %s dut%0d sym%0d: got %h expected %h", name, w, i, oat(w, i), eat(w, i));
                end
            end
        end
    endtask

    task automatic test_saturation();
        string name = "saturation";
        int smp[$];
        clear_q();
        smp = '{5000, -5000};
        model(0, smp, 1'b1); model(1, smp, 1'b1);
        send(smp, 1'b1, 1'b1, 1'b0, 1'b0);
        smp = '{0, -1};
        model(0, smp, 1'b1); model(1, smp, 1'b1);
        send(smp, 1'b1, 1'b1, 1'b1, 1'b0);
        drain();
        n_cmp++;
        if (obs_a.size() < 2 || obs_a[0] !== 14'b1_1_10_00_0111_1001 || obs_a[1] !== 14'b1_1_10_00_0000_0000) begin
            n_bad++;
            $display("FAIL %s dut0 directed: got %0d symbols (%h %h) expected 2 (%h %h)", name, obs_a.size(),
                     (obs_a.size() > 0) ? obs_a[0] : 14'h0, (obs_a.size() > 1) ? obs_a[1] : 14'h0,
                     14'b1_1_10_00_0111_1001, 14'b1_1_10_00_0000_0000);
        end
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (osz(w) !== esz(w)) begin
                n_bad++;
                $display("FAIL %s dut%0d symbol count: got %0d expected %0d", name, w, osz(w), esz(w));
            end
            for (int i = 0; i < esz(w) && i < osz(w); i++) begin
                n_cmp++;
                if (oat(w, i) !== eat(w, i)) begin
                    n_bad++;
                    $display("FAIL %s dut%0d sym%0d: got %h expected %h", name, w, i, oat(w, i), eat(w, i));
                end
            end
        end
    endtask

    task automatic test_punct();
        string name = "punct";
        int smp[$];
        clear_q();
        smp = '{1024, 1024, 1024, 1024, 1024, 1024};
        model(0, smp, 1'b1); model(1, smp, 1'b1);
        send(smp, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        n_cmp++;
        if (obs_b.size() != 4 || obs_b[0] !== 14'b1_0_11_00_0100_0100 || obs_b[1] !== 14'b0_0_10_01_0100_0000
            || obs_b[3] !== 14'b0_1_10_01_0100_0000) begin
            n_bad++;
            $display("FAIL %s dut1 directed: got %0d symbols first %h expected 4 symbols first %h", name,
                     obs_b.size(), (obs_b.size() > 0) ? obs_b[0] : 14'h0, 14'b1_0_11_00_0100_0100);
        end
        for (int p = 0; p < 5; p++) rand_pkt(1'b1, 9, 1'b1, 1'b1);
        drain();
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (osz(w) !== esz(w)) begin
                n_bad++;
                $display("FAIL %s dut%0d symbol count: got %0d expected %0d", name, w, osz(w), esz(w));
            end
            for (int i = 0; i < esz(w) && i < osz(w); i++) begin
                n_cmp++;
                if (oat(w, i) !== eat(w, i)) begin
                    n_bad++;
                    $display("FAIL %s dut%0d sym%0d: got %h expected %h", name, w, i, oat(w, i), eat(w, i));
                end
            end
        end
    endtask

    task automatic test_early_eop();
        string name = "early_eop";
        int smp[$];
        clear_q();
        smp = '{1024};
        model(0, smp, 1'b1); model(1, smp, 1'b1);
        send(smp, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({ifb.oval, ifb.osop, ifb.oeop, ifb.odat, ifb.oera, ifb.oLLR} !== {3'b111, 2'b10, 2'b01, 8'h40}) begin
            n_bad++;
            $display("FAIL %s dut1 single sample: got %h expected %h", name,
                     {ifb.oval, ifb.osop, ifb.oeop, ifb.odat, ifb.oera, ifb.oLLR}, {3'b111, 2'b10, 2'b01, 8'h40});
        end
        smp = '{-1024, 1024, 300};
        model(0, smp, 1'b1); model(1, smp, 1'b1);
        send(smp, 1'b1, 1'b1, 1'b1, 1'b0);
        drain();
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (osz(w) !== esz(w)) begin
                n_bad++;
                $display("FAIL %s dut%0d symbol count: got %0d expected %0d", name, w, osz(w), esz(w));
            end
            for (int i = 0; i < esz(w) && i < osz(w); i++) begin
                n_cmp++;
                if (oat(w, i) !== eat(w, i)) begin
                    n_bad++;
                    $display("FAIL %s dut%0d sym%0d: got %h expected %h", name, w, i, oat(w, i), eat(w, i));
                end
            end
        end
    endtask

    task automatic test_abort();
        string name = "abort";
        int smp[$];
        clear_q();
        smp = '{700};
        model(0, smp, 1'b0); model(1, smp, 1'b0);
        send(smp, 1'b1, 1'b0, 1'b0, 1'b0);
        smp = '{1024, 1024, 1024, 1024, 1024, 1024};
        model(0, smp, 1'b1); model(1, smp, 1'b1);
        send(smp, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int p = 0; p < 4; p++) begin
            rand_pkt(1'b0, 5, 1'b1, 1'b0);
            rand_pkt(1'b1, 7, 1'b1, 1'b1);
        end
        drain();
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (osz(w) !== esz(w)) begin
                n_bad++;
                $display("FAIL %s dut%0d symbol count: got %0d expected %0d", name, w, osz(w), esz(w));
            end
            for (int i = 0; i < esz(w) && i < osz(w); i++) begin
                n_cmp++;
                if (oat(w, i) !== eat(w, i)) begin
                    n_bad++;
                    $display("FAIL %s dut%0d sym%0d: got %h expected %h", name, w, i, oat(w, i), eat(w, i));
                end
            end
        end
    endtask

    task automatic test_async_reset_clkena();
        string name = "async_reset";
        int smp[$];
        clear_q();
        smp = '{1024, -1024, -700};
        model(0, smp, 1'b0); model(1, smp, 1'b0);
        send(smp, 1'b1, 1'b0, 1'b0, 1'b1);
        #2 ireset = 1'b0;
        #1;
        n_cmp++;
        if ({ifa.oval, ifa.osop, ifa.oeop, ifa.odat, ifa.oera, ifa.oLLR} !== 15'd0) begin
            n_bad++;
            $display("FAIL %s dut0 outputs: got %h expected 0", name, {ifa.oval, ifa.osop, ifa.oeop, ifa.odat, ifa.oera, ifa.oLLR});
        end
        n_cmp++;
        if ({ifb.oval, ifb.osop, ifb.oeop, ifb.odat, ifb.oera, ifb.oLLR} !== 15'd0) begin
            n_bad++;
            $display("FAIL %s dut1 outputs: got %h expected 0", name, {ifb.oval, ifb.osop, ifb.oeop, ifb.odat, ifb.oera, ifb.oLLR});
        end
        repeat (3) begin
            iclkena = 1'($urandom_range(0, 1));
            @(negedge iclk);
        end
        ireset  = 1'b1;
        iclkena = 1'b0;
        drive(1'b1, 1'b1, 1'b1, -2000);
        repeat (6) begin
            @(negedge iclk);
            n_cmp++;
            if (ifa.oval !== 1'b0 || ifb.oval !== 1'b0) begin
                n_bad++;
                $display("FAIL %s frozen oval: got %b%b expected 00", name, ifa.oval, ifb.oval);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 0);
        smp = '{1024, -1024};
        model(0, smp, 1'b1); model(1, smp, 1'b1);
        send(smp, 1'b1, 1'b1, 1'b0, 1'b1);
        drain();
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (osz(w) !== esz(w)) begin
                n_bad++;
                $display("FAIL %s dut%0d symbol count: got %0d expected %0d", name, w, osz(w), esz(w));
            end
            for (int i = 0; i < esz(w) && i < osz(w); i++) begin
                n_cmp++;
                if (oat(w, i) !== eat(w, i)) begin
                    n_bad++;
                    $display("FAIL %s dut%0d sym%0d: got %h expected %h", name, w, i, oat(w, i), eat(w, i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rate_half();
        test_saturation();
        test_punct();
        test_early_eop();
        test_abort();
        test_async_reset_clkena();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vit_llr_depunct.md
Name: vit_llr_depunct

Overview:
- Synthesizable channel front-end for the 1/N Viterbi decoder (vit_dec).
- Takes a serial stream of signed soft samples (one code bit per sample, punctured stream) and quantizes each to a pLLR_W LLR with saturation.
- Regroups the samples into pCODE_GEN_NUM-wide code symbols and reinserts erasures at punctured positions from a periodic puncture mask.
- Drives vit_dec isop/ival/ieop/idat/iLLR directly, enabling punctured rates (2/3, 3/4, ...) over a 1/N mother code.

Parameters:
pCODE_GEN_NUM  2  code bits per symbol (mother code 1/N)
pDAT_W  16  input sample width, signed
pREF_LOG2  10  log2 of the nominal constellation reference point (+-2^pREF_LOG2)
pLLR_W  4  output LLR width; 2 <= pLLR_W <= pREF_LOG2+2
pPUNCT_PERIOD  1  puncture pattern period, in symbols
pPUNCT_MASK  all ones  pCODE_GEN_NUM*pPUNCT_PERIOD bits; bit [c*pCODE_GEN_NUM+g] = 1 -> code bit g of column c is transmitted

Ports:
iclk  in  1  clock
ireset  in  1  reset, asynchronous, active-low
iclkena  in  1  clock enable; low freezes all state and outputs
isop  in  1  first sample of packet
ieop  in  1  last sample of packet
ival  in  1  sample valid
idat  in  pDAT_W  signed soft sample
osop  out  1  first symbol of packet
oeop  out  1  last symbol of packet
oval  out  1  symbol valid
odat  out  pCODE_GEN_NUM  hard bits; 1 = non-negative sample; 0 at erasures
oLLR  out  pLLR_W x pCODE_GEN_NUM  signed LLR array, index g; 0 at erasures
oera  out  pCODE_GEN_NUM  erasure mask; 1 = punctured position

Behaviour:
- Reset: ireset low clears all outputs to 0, the column pointer to 0 and the slot pointer to the first kept slot. Reset takes effect asynchronously, mid-packet included, and any partial symbol is discarded.
- Quantization (per accepted sample):
  - sat = clamp(idat, -(2^(pREF_LOG2+1)-1), +(2^(pREF_LOG2+1)-1)).
  - llr = (sat >>> (pREF_LOG2+2-pLLR_W)) + sign(sat), taken modulo 2^pLLR_W.
  - Output range is symmetric, +-(2^(pLLR_W-1)-1); overflow cannot occur.
  - hard bit = !sign(sat).
- Slot order within a column: code bit index pCODE_GEN_NUM-1 first, down to 0. Punctured slots (mask bit 0) consume no input sample.
- Legality: every column of pPUNCT_MASK has at least one kept bit. Therefore the output rate never exceeds the input rate, and no backpressure port exists.
- Column assembly:
  - Kept samples are written into a symbol register at the current slot.
  - Once the last kept slot of the column is written, the symbol is issued with oval=1 on the next enabled clock. Latency is 1 cycle from the final sample.
  - The column pointer then advances modulo pPUNCT_PERIOD, and the slot pointer moves to the first kept slot of the new column.
- Erasure slots carry oLLR=0, odat=0, oera=1.
- osop is set on the first symbol after an accepted isop.
- isop with ival: the column pointer resets to 0 before the sample is placed, so every packet starts at column 0.
- isop mid-packet: the partial symbol and packet are dropped; no oeop is emitted for the aborted packet.
- ieop with ival:
  - The current symbol is issued on the next cycle with oeop=1, even if the column is incomplete; unfilled kept slots become erasures (oera=1).
  - The pointers reset to column 0 afterwards.
- isop and ieop together: a single-sample packet, output with osop=oeop=1.
- Gaps (ival=0) between samples: allowed anywhere; state is held.
- oval is a single-cycle pulse per symbol. osop/oeop are valid only when oval=1 and are 0 otherwise.
- Registered state: column counter, slot counter, partial symbol register, sop-pending flag, output registers.

Test Plan:
- Unpunctured rate 1/2, defaults, samples +1024, -1024 -> one symbol: oLLR[1]=+4, oLLR[0]=-3, odat=2'b10, oera=0, oval one cycle after the 2nd sample.
- Saturation and rounding: samples +5000, -5000, 0, -1 (two packets) -> LLRs +7, -7, then 0, 0; odat = 10, then 10.
- Rate 2/3, pPUNCT_PERIOD=2, pPUNCT_MASK=4'b1011, 6 samples +1024 -> 4 symbols; columns 1 and 3 have oLLR[0]=0, oera=2'b01; osop on symbol 0, oeop on symbol 3.
- Early ieop in rate 2/3 after one sample of column 0 -> single symbol with oLLR[0]=0, oera=2'b01, osop=oeop=1.
- isop arriving mid-column -> partial symbol dropped, no oeop for the aborted packet, new packet's first symbol has osop=1 and column 0 alignment.
- Async reset asserted mid-packet with iclkena toggling -> outputs 0 immediately; the next isop packet decodes as in the first scenario; with iclkena=0, oval is never asserted and state is unchanged.
